// File: rtl/sh2_wait_gen_pkg.sv
// Shared types for the SH-2 wait-state generator: region/state encodings,
// MEM_SEL codes and the select-priority decode.
package sh2_wait_gen_pkg;

   typedef enum logic [1:0] {
      REG_ROM  = 2'd0,
      REG_SRAM = 2'd1,
      REG_DRAM = 2'd2,
      REG_SMPC = 2'd3
   } region_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [1:0] SEL_ROM  = 2'd0;
   localparam logic [1:0] SEL_SRAM = 2'd1;
   localparam logic [1:0] SEL_DRAM = 2'd2;

   // Several selects low at once resolve as SMPC > SRAM > ROM > DRAM.
   function automatic region_t pick_region(input logic romce_n, input logic smpcce_n,
                                           input logic sramce_n, input logic dce_n);
      region_t r;
      if (!smpcce_n)      r = REG_SMPC;
      else if (!sramce_n) r = REG_SRAM;
      else if (!romce_n)  r = REG_ROM;
      else                r = REG_DRAM;
      if (dce_n && romce_n && sramce_n && smpcce_n) r = REG_DRAM;
      return r;
   endfunction

   function automatic logic [1:0] sel_of(input region_t r);
      logic [1:0] s;
      case (r)
         REG_SRAM: s = SEL_SRAM;
         REG_DRAM: s = SEL_DRAM;
         default:  s = SEL_ROM;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/sh2_wait_gen.sv
// Wait-state generator behind the SH-2 chip-select decoder: holds WTIN_N low
// for the larger of a per-region wait count and the back-end ready handshake.
module sh2_wait_gen
   import sh2_wait_gen_pkg::*;
#(
   parameter int ROM_WS  = 2,
   parameter int SMPC_WS = 3,
   parameter int SRAM_WS = 1,
   parameter int DRAM_WS = 1,
   parameter int TIMEOUT = 255
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       CE_R,
   input  logic       CE_F,
   input  logic       ROMCE_N,
   input  logic       SMPCCE_N,
   input  logic       SRAMCE_N,
   input  logic       DCE_N,
   input  logic       RD_N,
   input  logic [1:0] DWE_N,
   input  logic       MEM_RDY,
   output logic       WTIN_N,
   output logic       MEM_REQ,
   output logic       MEM_WR,
   output logic [1:0] MEM_SEL,
   output logic       BUS_TMO,
   output logic [1:0] DBG_STATE
);

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   logic [7:0] cnt;
   logic [7:0] to_cnt;
   logic       ack;

   logic       any_sel;
   logic       access;
   region_t    region_nxt;
   logic [7:0] ws_load;

   assign any_sel    = ~&{ROMCE_N, SMPCCE_N, SRAMCE_N, DCE_N};
   assign access     = any_sel & (~RD_N | ~&DWE_N);
   assign region_nxt = pick_region(ROMCE_N, SMPCCE_N, SRAMCE_N, DCE_N);
   assign DBG_STATE  = state;

   always_comb begin
      ws_load = 8'd0;
      case (region_nxt)
         REG_ROM:  ws_load = 8'(ROM_WS - 1);
         REG_SRAM: ws_load = 8'(SRAM_WS - 1);
         REG_DRAM: ws_load = 8'(DRAM_WS - 1);
         default:  ws_load = 8'(SMPC_WS - 1);
      endcase
   end

   // Back-end handshake: MEM_REQ is a single-CLK pulse; MEM_RDY is a pulse that
   // may arrive on any later CLK (even the MEM_REQ cycle) and is latched as ack.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= ST_IDLE;
         cnt     <= 8'd0;
         to_cnt  <= 8'd0;
         ack     <= 1'b0;
         MEM_REQ <= 1'b0;
         MEM_WR  <= 1'b0;
         MEM_SEL <= SEL_ROM;
         BUS_TMO <= 1'b0;
         WTIN_N  <= 1'b1;
      end else begin
         MEM_REQ <= 1'b0;
         if (CE_F) WTIN_N <= (state != ST_WAIT);
         case (state)
            ST_IDLE: begin
               if (CE_R && access) begin
                  MEM_WR <= ~&DWE_N;
                  cnt    <= ws_load;
                  to_cnt <= 8'd0;
                  state  <= ST_WAIT;
                  if (region_nxt == REG_SMPC) begin
                     ack <= 1'b1;
                  end else begin
                     ack     <= 1'b0;
                     MEM_REQ <= 1'b1;
                     MEM_SEL <= sel_of(region_nxt);
                  end
               end
            end
            ST_WAIT: begin
               if (MEM_RDY) ack <= 1'b1;
               if (CE_R) begin
                  if (cnt == 8'd0 && ack) begin
                     state <= ST_DONE;
                  end else begin
                     if (cnt != 8'd0) cnt <= cnt - 8'd1;
                     to_cnt <= to_cnt + 8'd1;
                     // Forced release keeps a dead back-end from hanging the bus.
                     if (to_cnt == TMO_LAST) begin
                        state   <= ST_DONE;
                        BUS_TMO <= 1'b1;
                     end
                  end
               end
            end
            ST_DONE: begin
               if (CE_R && !access) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sh2_wait_gen.sv
// Bench for sh2_wait_gen: counts WTIN_N-low CE_R edges per access and checks
// them against expected lengths queued by the driver.
module tb_sh2_wait_gen;
   import sh2_wait_gen_pkg::*;

   localparam int W   = 9;
   localparam int TMO = 255;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       CE_R = 1'b0;
   logic       CE_F = 1'b0;
   logic       ROMCE_N = 1'b1;
   logic       SMPCCE_N = 1'b1;
   logic       SRAMCE_N = 1'b1;
   logic       DCE_N = 1'b1;
   logic       RD_N = 1'b1;
   logic [1:0] DWE_N = 2'b11;
   logic       MEM_RDY = 1'b0;
   logic       WTIN_N;
   logic       MEM_REQ;
   logic       MEM_WR;
   logic [1:0] MEM_SEL;
   logic       BUS_TMO;
   logic [1:0] DBG_STATE;

   logic [W-1:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;
   int low_run = 0;
   int req_cnt = 0;

   sh2_wait_gen dut (
      .CLK(CLK), .RST(RST), .CE_R(CE_R), .CE_F(CE_F),
      .ROMCE_N(ROMCE_N), .SMPCCE_N(SMPCCE_N), .SRAMCE_N(SRAMCE_N), .DCE_N(DCE_N),
      .RD_N(RD_N), .DWE_N(DWE_N), .MEM_RDY(MEM_RDY),
      .WTIN_N(WTIN_N), .MEM_REQ(MEM_REQ), .MEM_WR(MEM_WR), .MEM_SEL(MEM_SEL),
      .BUS_TMO(BUS_TMO), .DBG_STATE(DBG_STATE)
   );

   // ---------------- clock / enables ----------------
   always #5 CLK = ~CLK;

   initial begin : ce_gen
      int phase;
      phase = 0;
      forever begin
         @(posedge CLK);
         #2;
         phase = (phase + 1) % 4;
         CE_R = (phase == 0);
         CE_F = (phase == 2);
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d", tag, act, exp);
      end
   endtask

   // Samples WTIN_N just before each CE_R edge, as the CPU sees it.
   initial begin : monitor
      forever begin
         @(negedge CLK);
         if (RST) begin
            low_run = 0;
         end else begin
            if (MEM_REQ) req_cnt++;
            if (CE_R) begin
               if (!WTIN_N) begin
                  low_run++;
               end else if (low_run > 0) begin
                  if (exp_q.size() == 0) check("unexp_release", low_run, 0);
                  else check("wait_len", low_run, 32'(exp_q.pop_front()));
                  low_run = 0;
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_ce_r();
      do @(negedge CLK); while (!CE_R);
   endtask

   task automatic idle_bus();
      {SMPCCE_N, SRAMCE_N, ROMCE_N, DCE_N} = 4'b1111;
      RD_N = 1'b1;
      DWE_N = 2'b11;
      MEM_RDY = 1'b0;
   endtask

   // ce_n order: {SMPC, SRAM, ROM, DRAM}; rdy_d < 0 means MEM_RDY never comes.
   task automatic access(input string nm, input logic [3:0] ce_n, input logic rd_n,
                         input logic [1:0] dwe_n, input int rdy_d, input int ws,
                         input logic [1:0] exp_sel, input logic exp_wr,
                         input int exp_req, input logic exp_tmo);
      int len;
      int budget;
      wait_ce_r();
      req_cnt = 0;
      {SMPCCE_N, SRAMCE_N, ROMCE_N, DCE_N} = ce_n;
      RD_N = rd_n;
      DWE_N = dwe_n;
      if (exp_req == 0)   len = ws;
      else if (rdy_d < 0) len = TMO;
      else                len = (ws > rdy_d + 1) ? ws : rdy_d + 1;
      exp_q.push_back(W'(len));
      if (exp_req != 0 && rdy_d >= 0) begin
         for (int i = 0; i < rdy_d; i++) wait_ce_r();
         @(negedge CLK);
         MEM_RDY = 1'b1;
         @(negedge CLK);
         MEM_RDY = 1'b0;
      end
      budget = 0;
      while (exp_q.size() != 0 && budget < 4000) begin
         @(negedge CLK);
         budget++;
      end
      if (exp_q.size() != 0) begin
         check({nm, "_release_bound"}, exp_q.size(), 0);
         exp_q.delete();
      end
      check({nm, "_req"}, req_cnt, exp_req);
      check({nm, "_wr"}, MEM_WR, exp_wr);
      if (exp_req != 0) check({nm, "_sel"}, MEM_SEL, exp_sel);
      check({nm, "_tmo"}, BUS_TMO, exp_tmo);
      idle_bus();
      repeat (3) wait_ce_r();
      check({nm, "_idle"}, DBG_STATE, ST_IDLE);
      check({nm, "_wtin_hi"}, WTIN_N, 1'b1);
   endtask

   // ---------------- stimulus ----------------
   initial begin : main
      logic [3:0] ce_tab[3];
      int         ws_tab[3];
      logic [1:0] sel_tab[3];
      ce_tab  = '{4'b1101, 4'b1011, 4'b1110};
      ws_tab  = '{2, 1, 1};
      sel_tab = '{SEL_ROM, SEL_SRAM, SEL_DRAM};

      repeat (3) @(negedge CLK);
      check("rst_wtin", WTIN_N, 1'b1);
      check("rst_req", MEM_REQ, 1'b0);
      check("rst_wr", MEM_WR, 1'b0);
      check("rst_sel", MEM_SEL, 2'd0);
      check("rst_tmo", BUS_TMO, 1'b0);
      check("rst_state", DBG_STATE, ST_IDLE);
      RST = 1'b0;
      repeat (2) wait_ce_r();

      access("rom_rd", 4'b1101, 1'b0, 2'b11, 0, 2, SEL_ROM, 1'b0, 1, 1'b0);
      access("dram_wr", 4'b1110, 1'b1, 2'b01, 10, 1, SEL_DRAM, 1'b1, 1, 1'b0);
      access("smpc_rd", 4'b0111, 1'b0, 2'b11, -1, 3, SEL_ROM, 1'b0, 0, 1'b0);
      access("smpc_rom", 4'b0101, 1'b0, 2'b11, -1, 3, SEL_ROM, 1'b0, 0, 1'b0);
      access("sram_tmo", 4'b1011, 1'b0, 2'b11, -1, 1, SEL_SRAM, 1'b0, 1, 1'b1);
      access("rom_wr", 4'b1101, 1'b1, 2'b10, 3, 2, SEL_ROM, 1'b1, 1, 1'b1);

      // Reset in the middle of a wait.
      wait_ce_r();
      SRAMCE_N = 1'b0;
      RD_N = 1'b0;
      repeat (5) wait_ce_r();
      check("mid_wtin_lo", WTIN_N, 1'b0);
      RST = 1'b1;
      req_cnt = 0;
      #1;
      check("mid_rst_wtin", WTIN_N, 1'b1);
      check("mid_rst_state", DBG_STATE, ST_IDLE);
      check("mid_rst_tmo", BUS_TMO, 1'b0);
      idle_bus();
      repeat (2) wait_ce_r();
      RST = 1'b0;
      repeat (4) wait_ce_r();
      check("post_rst_req", req_cnt, 0);

      access("rom_after_rst", 4'b1101, 1'b0, 2'b11, 0, 2, SEL_ROM, 1'b0, 1, 1'b0);

      for (int i = 0; i < 4; i++) begin
         int r;
         int d;
         r = $urandom_range(0, 2);
         d = $urandom_range(0, 6);
         access("rand", ce_tab[r], 1'b0, 2'b11, d, ws_tab[r], sel_tab[r], 1'b0, 1, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sh2_wait_gen.md
# sh2_wait_gen

Wait-state generator sitting directly downstream of the SH-2 bus chip-select decoder. It consumes the decoded region selects and read/write strobes, issues a one-cycle request to the memory back-end, and drives the WTIN_N input of the decoder, which forwards it to the CPU as WAIT_N. Wait length per region is the larger of a fixed per-region wait count and the back-end's ready handshake. A timeout guarantees the bus never hangs.

## Interface
- ROM_WS, 2: minimum wait-sampled CE_R edges for BIOS ROM (≥1)
- SMPC_WS, 3: wait edges for SMPC (internal, no back-end request)
- SRAM_WS, 1: wait edges for backup SRAM
- DRAM_WS, 1: wait edges for work DRAM low (DCE_N)
- TIMEOUT, 255: max CE_R edges in WAIT before forced release (8-bit)

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-high reset
- CE_R  in  1  rising-phase clock enable; CPU samples WAIT here
- CE_F  in  1  falling-phase clock enable; WTIN_N updates here
- ROMCE_N, SMPCCE_N, SRAMCE_N, DCE_N  in  1 each  region selects, active low
- RD_N  in  1  read strobe, active low
- DWE_N  in  2  byte write strobes, active low
- MEM_RDY  in  1  back-end ready pulse, any CLK
- WTIN_N  out  1  wait to decoder, active low
- MEM_REQ  out  1  one-CLK request pulse
- MEM_WR  out  1  1 = write, held valid from MEM_REQ to release
- MEM_SEL  out  2  0 ROM, 1 SRAM, 2 DRAM; held like MEM_WR
- BUS_TMO  out  1  sticky timeout flag

## Operation
- Reset values: WTIN_N=1, MEM_REQ=0, MEM_WR=0, MEM_SEL=0, BUS_TMO=0, state IDLE, counters 0, ack 0.
- Access condition: any select low AND (RD_N=0 OR any DWE_N bit 0).
- Region priority when several selects are low: SMPC > SRAM > ROM > DRAM.
- States:
  - IDLE: on CE_R with access condition: latch region and MEM_WR=~&DWE_N, load cnt=WS−1, clear to_cnt and ack, go WAIT. For a memory region, pulse MEM_REQ on the next CLK. For SMPC, set ack=1 and do not request.
  - WAIT: MEM_RDY on any CLK sets ack. Ack stays set until the next access, including when MEM_RDY coincides with the MEM_REQ cycle. On CE_R:
    - cnt==0 AND ack: go DONE.
    - else: decrement cnt if nonzero and increment to_cnt.
    - to_cnt==TIMEOUT−1: go DONE and set BUS_TMO.
  - DONE: on CE_R, if all selects are high OR (RD_N=1 AND DWE_N=2'b11), go IDLE. A new access is only accepted from IDLE.
- WTIN_N is registered on CE_F as WTIN_N = (state != WAIT).
- MEM_RDY outside WAIT is ignored.
- Reset mid-access returns to IDLE immediately. WTIN_N is released asynchronously, and no MEM_REQ is issued afterwards.

## Timing
- Access is detected at CE_R edge k. MEM_REQ is high for the single CLK after edge k. WTIN_N falls at the first CE_F after k.
- With ack already present, WTIN_N is sampled low at exactly WS CE_R edges (k+1 … k+WS). It rises at the CE_F following edge k+WS.
- With late ack: release happens at the first CE_R where cnt==0 and ack is set. WTIN_N rises at the next CE_F.
- Timeout: WTIN_N is sampled low at most TIMEOUT edges.
- CE_R and CE_F never coincide. Behaviour is defined only for alternating enables.

## Structure
- A shared package holds:
  - region enum: ROM, SRAM, DRAM, SMPC
  - state enum: IDLE, WAIT, DONE
  - the MEM_SEL encoding constants
- No sub-module. The counters and FSM are a single process group.

## Test plan
- ROM read, MEM_RDY 1 CLK after MEM_REQ, ROM_WS=2 -> MEM_SEL=0, MEM_WR=0, WTIN_N low at edges k+1,k+2, high by k+3.
- DRAM write DWE_N=2'b01, MEM_RDY 10 CE_R edges late -> MEM_WR=1, MEM_SEL=2, WTIN_N low until the edge after ack.
- SMPC read -> no MEM_REQ, WTIN_N low exactly 3 edges.
- SRAM access with MEM_RDY never asserted -> release after 255 edges, BUS_TMO=1 and stays 1.
- SMPCCE_N and ROMCE_N both low -> treated as SMPC, no request.
- RST asserted in WAIT -> WTIN_N=1 immediately, no MEM_REQ after reset; next access behaves normally.
